// File: rtl/aes_pkg.sv
// Shared Rijndael types and constants for the AES datapath stages.
package aes_pkg;

  localparam int NB_128 = 4;
  localparam int NB_192 = 6;
  localparam int NB_256 = 8;
  localparam int NB_MAX = NB_256;

  typedef logic [7:0]            byte_t;
  typedef logic [31:0]           word_t;
  typedef logic [32*NB_MAX-1:0]  state_max_t;

  // Row rotation amounts; the 256-bit block uses a wider spread on rows 2 and 3.
  function automatic int sh_off(input int nb, input int r);
    if (r < 2) return r;
    if (nb == NB_256) return r + 1;
    return r;
  endfunction

endpackage

// File: rtl/aes_shiftrows_core.sv
// Combinational ShiftRows permutation for an NB-column Rijndael state.
// The inverse permutation is built only when AES_SHIFTROWS_INV_EN is defined.
module aes_shiftrows_core #(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] in_state,
`ifdef AES_SHIFTROWS_INV_EN
  input  logic             inv,
`endif
  output logic [32*NB-1:0] out_state
);
  import aes_pkg::*;

  localparam int W = 32*NB;

  // Byte r+4c lives at bits [W-1-8*(r+4c) -: 8]; every output byte is a pure wire pick.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int DST  = r + 4*c;
      localparam int FCOL = (c + sh_off(NB, r)) % NB;
      localparam int FSRC = r + 4*FCOL;
      byte_t fwd_byte;
      assign fwd_byte = in_state[W-1-8*FSRC -: 8];
`ifdef AES_SHIFTROWS_INV_EN
      localparam int ICOL = (c - sh_off(NB, r) + NB) % NB;
      localparam int ISRC = r + 4*ICOL;
      byte_t inv_byte;
      assign inv_byte = in_state[W-1-8*ISRC -: 8];
      assign out_state[W-1-8*DST -: 8] = inv ? inv_byte : fwd_byte;
`else
      assign out_state[W-1-8*DST -: 8] = fwd_byte;
`endif
    end
  end

endmodule

// File: rtl/aes_shiftrows_pipe.sv
// Pipelined ShiftRows/InvShiftRows stage with valid/ready flow control and a sideband tag.
// Optional per-entry inverse mode is enabled by defining AES_SHIFTROWS_INV_EN.
module aes_shiftrows_pipe #(
  parameter int NB     = 4,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [32*NB-1:0]   in_state,
  input  logic               in_inv,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [32*NB-1:0]   out_state,
  output logic [TAG_W-1:0]   out_tag
);
  import aes_pkg::*;

  localparam int W = 32*NB;

  if (!(NB == NB_128 || NB == NB_192 || NB == NB_256)) begin : g_bad_nb
    $error("aes_shiftrows_pipe: NB must be 4, 6 or 8");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("aes_shiftrows_pipe: STAGES must be 1..4");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("aes_shiftrows_pipe: TAG_W must be at least 1");
  end

  logic [STAGES:1] v;
  logic [STAGES:1] rdy;
  logic [W-1:0]     st_q  [1:STAGES];
  logic [TAG_W-1:0] tag_q [1:STAGES];
  logic [W-1:0]     shifted;

`ifdef AES_SHIFTROWS_INV_EN
  aes_shiftrows_core #(.NB(NB)) u_core (
    .in_state  (in_state),
    .inv       (in_inv),
    .out_state (shifted)
  );
`else
  logic unused_inv;
  assign unused_inv = in_inv;

  aes_shiftrows_core #(.NB(NB)) u_core (
    .in_state  (in_state),
    .out_state (shifted)
  );
`endif

  // Stage k can move when any stage from k to the output is empty or the sink takes data.
  for (genvar k = 1; k <= STAGES; k++) begin : g_rdy
    assign rdy[k] = out_ready | ~(&v[STAGES:k]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= STAGES; k++) begin
        v[k]     <= 1'b0;
        st_q[k]  <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      if (rdy[1]) v[1] <= in_valid;
      if (rdy[1] && in_valid) begin
        st_q[1]  <= shifted;
        tag_q[1] <= in_tag;
      end
      // Data only moves on a real transfer so bubbles never clobber held entries.
      for (int k = 2; k <= STAGES; k++) begin
        if (rdy[k]) v[k] <= v[k-1];
        if (rdy[k] && v[k-1]) begin
          st_q[k]  <= st_q[k-1];
          tag_q[k] <= tag_q[k-1];
        end
      end
    end
  end

  assign in_ready  = rdy[1];
  assign out_valid = v[STAGES];
  assign out_state = st_q[STAGES];
  assign out_tag   = tag_q[STAGES];

endmodule

// File: tb/tb_aes_shiftrows_pipe.sv
// Self-checking bench for aes_shiftrows_pipe: NB=4/STAGES=2 main instance plus an NB=8 instance.
module tb_aes_shiftrows_pipe;

  localparam int NB     = 4;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;
  localparam int W      = 32*NB;
  localparam int NBB    = 8;
  localparam int STB    = 1;
  localparam int TWB    = 3;
  localparam int WB     = 32*NBB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             in_valid, in_ready, in_inv, out_valid, out_ready;
  logic [W-1:0]     in_state, out_state;
  logic [TAG_W-1:0] in_tag, out_tag;

  logic             b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready;
  logic [WB-1:0]    b_in_state, b_out_state;
  logic [TWB-1:0]   b_in_tag, b_out_tag;

  aes_shiftrows_pipe #(.NB(NB), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .in_inv(in_inv), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_state(out_state), .out_tag(out_tag)
  );

  aes_shiftrows_pipe #(.NB(NBB), .STAGES(STB), .TAG_W(TWB)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_state(b_in_state),
    .in_inv(b_in_inv), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_state(b_out_state), .out_tag(b_out_tag)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int pops = 0;
  int step_no = 0;
  int first_pop = -1;
  int last_pop = -1;
  bit check_ready_en = 1'b0;
  bit last_in_xfer = 1'b0;

  logic [W-1:0]     exp_state_q [$];
  logic [TAG_W-1:0] exp_tag_q   [$];

  // Reference: rebuild the byte grid and rotate each row by its offset.
  function automatic logic [255:0] shift_ref(input logic [255:0] s, input int nb, input bit inv);
    logic [7:0] src [32];
    logic [7:0] dst [32];
    logic [255:0] res;
    int w, sh, col;
    w = 32*nb;
    res = '0;
    for (int i = 0; i < 4*nb; i++) src[i] = s[w-1-8*i -: 8];
    for (int r = 0; r < 4; r++) begin
      sh = (nb == 8 && r >= 2) ? r + 1 : r;
      for (int c = 0; c < nb; c++) begin
        col = inv ? (c - sh + nb) % nb : (c + sh) % nb;
        dst[r+4*c] = src[r+4*col];
      end
    end
    for (int i = 0; i < 4*nb; i++) res[w-1-8*i -: 8] = dst[i];
    return res;
  endfunction

  function automatic bit inv_eff(input bit inv);
`ifdef AES_SHIFTROWS_INV_EN
    return inv;
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] s, input logic [TAG_W-1:0] t,
                               input bit inv, input bit valid, input bit ordy);
    in_state  = s;
    in_tag    = t;
    in_inv    = inv;
    in_valid  = valid;
    out_ready = ordy;
  endtask

  // One cycle of the main instance: compare against the scoreboard, then cross the edge.
  task automatic stepCycle();
    logic [255:0] m;
    #1;
    if (check_ready_en)
      checkOutput("in_ready", in_ready, (exp_state_q.size() < STAGES) || out_ready);
    if (out_valid) begin
      if (exp_state_q.size() == 0) begin
        checkOutput("spurious_out", out_valid, 1'b0);
      end else begin
        checkOutput("out_state", out_state, exp_state_q[0]);
        checkOutput("out_tag", out_tag, exp_tag_q[0]);
        if (out_ready) begin
          void'(exp_state_q.pop_front());
          void'(exp_tag_q.pop_front());
          pops++;
          if (first_pop < 0) first_pop = step_no;
          last_pop = step_no;
        end
      end
    end
    last_in_xfer = in_valid && in_ready;
    if (last_in_xfer) begin
      m = shift_ref({128'h0, in_state}, NB, inv_eff(in_inv));
      exp_state_q.push_back(m[W-1:0]);
      exp_tag_q.push_back(in_tag);
    end
    step_no++;
    @(negedge clk);
  endtask

  task automatic measureLatency(input string label);
    int lat;
    lat = 1;
    #1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    checkOutput({label, "_latency"}, lat, STAGES);
  endtask

  task automatic sendB(input logic [WB-1:0] s, input bit inv, input logic [TWB-1:0] t,
                       input string label, output logic [WB-1:0] res);
    int lat;
    b_in_state = s; b_in_inv = inv; b_in_tag = t; b_in_valid = 1'b1; b_out_ready = 1'b1;
    #1;
    checkOutput({label, "_rdy"}, b_in_ready, 1'b1);
    @(negedge clk);
    b_in_valid = 1'b0;
    lat = 1;
    #1;
    while (!b_out_valid && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    checkOutput({label, "_latency"}, lat, STB);
    checkOutput({label, "_state"}, b_out_state, shift_ref(s, NBB, inv_eff(inv)));
    checkOutput({label, "_tag"}, b_out_tag, t);
    res = b_out_state;
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0]  idx, idx_out, fips_in, fips_out;
    logic [W-1:0]  bp_states [6];
    logic [WB-1:0] b_idx, b_res, b_res2;
    int sent, pops_before, cyc;

    fips_in  = 128'hd42711aee0bf98f1b8b45de51e415230;
    fips_out = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    idx      = 128'h000102030405060708090a0b0c0d0e0f;
    idx_out  = 128'h00050a0f04090e03080d02070c01060b;
    for (int i = 0; i < 32; i++) b_idx[WB-1-8*i -: 8] = 8'(i);

    rst_n = 1'b0;
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
    b_in_valid = 1'b0; b_in_state = '0; b_in_inv = 1'b0; b_in_tag = '0; b_out_ready = 1'b1;
    #3;
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_state", out_state, '0);
    checkOutput("rst_out_tag", out_tag, '0);
    checkOutput("rst_in_ready_empty", in_ready, 1'b1);
    checkOutput("rst_b_out_valid", b_out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("empty_ready_no_sink", in_ready, 1'b1);
    @(negedge clk);
    $display("[TB] reset checks done");

    check_ready_en = 1'b1;
    applyStimulus(fips_in, 4'h5, 1'b0, 1'b1, 1'b1);
    stepCycle();
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b1);
    measureLatency("fips");
    checkOutput("fips_const", out_state, fips_out);
    checkOutput("fips_tag", out_tag, 4'h5);
    stepCycle();

    applyStimulus(idx, 4'h9, 1'b0, 1'b1, 1'b1);
    stepCycle();
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b1);
    measureLatency("idx");
    checkOutput("idx_const", out_state, idx_out);
    stepCycle();

`ifdef AES_SHIFTROWS_INV_EN
    applyStimulus(idx_out, 4'h3, 1'b1, 1'b1, 1'b1);
    stepCycle();
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b1);
    measureLatency("idx_inv");
    checkOutput("idx_inv_const", out_state, idx);
    stepCycle();
`endif

    // Backpressure: sink stalls on cycles 3..7 while six states stream in.
    for (int i = 0; i < 6; i++) bp_states[i] = {$urandom, $urandom, $urandom, $urandom};
    sent = 0;
    pops_before = pops;
    cyc = 1;
    while ((sent < 6 || exp_state_q.size() != 0) && cyc < 40) begin
      applyStimulus(sent < 6 ? bp_states[sent] : '0, 4'(sent), 1'($urandom_range(0, 1)),
                    sent < 6, !(cyc >= 3 && cyc <= 7));
      stepCycle();
      if (last_in_xfer) sent++;
      cyc++;
    end
    checkOutput("bp_delivered", pops - pops_before, 6);

    // Back-to-back streaming with an always-ready sink.
    pops_before = pops;
    first_pop = -1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus({$urandom, $urandom, $urandom, $urandom}, 4'(i), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
      stepCycle();
    end
    cyc = 0;
    while (exp_state_q.size() != 0 && cyc < 20) begin
      applyStimulus('0, '0, 1'b0, 1'b0, 1'b1);
      stepCycle();
      cyc++;
    end
    checkOutput("b2b_delivered", pops - pops_before, 16);
    checkOutput("b2b_consecutive", last_pop - first_pop, 15);

    // Random traffic with random sink stalls.
    for (int i = 0; i < 80; i++) begin
      applyStimulus({$urandom, $urandom, $urandom, $urandom}, 4'($urandom), 1'($urandom_range(0, 1)),
                    ($urandom % 4) != 0, ($urandom % 3) != 0);
      stepCycle();
    end
    cyc = 0;
    while (exp_state_q.size() != 0 && cyc < 20) begin
      applyStimulus('0, '0, 1'b0, 1'b0, 1'b1);
      stepCycle();
      cyc++;
    end
    checkOutput("rand_drain_empty", exp_state_q.size(), 0);

    // Reset with two entries held in the pipeline.
    applyStimulus(32'hdeadbeef, 4'hA, 1'b0, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(32'hcafef00d, 4'hB, 1'b0, 1'b1, 1'b0);
    stepCycle();
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_reset_valid", out_valid, 1'b1);
    check_ready_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", out_valid, 1'b0);
    checkOutput("midrst_out_state", out_state, '0);
    checkOutput("midrst_out_tag", out_tag, '0);
    checkOutput("midrst_in_ready", in_ready, 1'b1);
    exp_state_q.delete();
    exp_tag_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_ready_en = 1'b1;
    applyStimulus(fips_in, 4'h7, 1'b0, 1'b1, 1'b1);
    stepCycle();
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b1);
    measureLatency("post_reset");
    checkOutput("post_reset_const", out_state, fips_out);
    stepCycle();
    stepCycle();
    checkOutput("post_reset_empty", exp_state_q.size(), 0);

    // 256-bit block instance.
    sendB(b_idx, 1'b0, 3'h2, "nb8_idx", b_res);
    checkOutput("nb8_col0", b_res[WB-1 -: 32], 32'h00050e13);
`ifdef AES_SHIFTROWS_INV_EN
    sendB(b_res, 1'b1, 3'h5, "nb8_inv", b_res2);
    checkOutput("nb8_restore", b_res2, b_idx);
`endif
    for (int i = 0; i < 4; i++)
      sendB({8{$urandom}}, 1'($urandom_range(0, 1)), 3'($urandom), "nb8_rand", b_res2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
